psum_gbf_reader: RTL and testbench

PSUM_GBF_READER -- requirements
Module: psum_gbf_reader

---
 rtl/psum_gbf_pkg.sv | 26 ++
 rtl/psum_word_serializer.sv | 48 ++++
 rtl/psum_gbf_reader.sv | 134 +++++++++++++
 tb/tb_psum_gbf_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_gbf_pkg.sv
// Shared FSM encoding and beat-geometry helpers for the psum global-buffer reader.
package psum_gbf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_GBF_DATA_BITWIDTH = 512;
  localparam int DEF_OUT_BITWIDTH      = 64;
  localparam int BEATS_PER_WORD        = DEF_GBF_DATA_BITWIDTH / DEF_OUT_BITWIDTH;
  localparam int BEAT_CNT_BITWIDTH     = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

  // Parameterised forms so instances with non-default widths stay self-consistent.
  function automatic int beats_per_word(input int gbf_bits, input int out_bits);
    return gbf_bits / out_bits;
  endfunction

  function automatic int beat_cnt_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/psum_word_serializer.sv
// Holds one BRAM word and slices it into stream beats, LSB beat first.
module psum_word_serializer
  import psum_gbf_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int OUT_BITWIDTH      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          capture,
  input  logic                          advance,
  input  logic [GBF_DATA_BITWIDTH-1:0]  word_in,
  output logic [OUT_BITWIDTH-1:0]       out_data,
  output logic [beat_cnt_bits(beats_per_word(GBF_DATA_BITWIDTH, OUT_BITWIDTH))-1:0] beat_cnt,
  output logic                          final_beat
);

  localparam int BEATS = beats_per_word(GBF_DATA_BITWIDTH, OUT_BITWIDTH);
  localparam int BCW   = beat_cnt_bits(BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  logic [GBF_DATA_BITWIDTH-1:0] word_q;
  logic [BCW-1:0]               beat_q;
  logic [OUT_BITWIDTH-1:0]      lanes [BEATS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q <= '0;
      beat_q <= '0;
    end else if (capture) begin
      word_q <= word_in;
      beat_q <= '0;
    end else if (advance) begin
      beat_q <= final_beat ? '0 : beat_q + BCW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      lanes[i] = word_q[i*OUT_BITWIDTH +: OUT_BITWIDTH];
    end
  end

  assign out_data   = lanes[beat_q];
  assign beat_cnt   = beat_q;
  assign final_beat = (beat_q == LAST_BEAT);

endmodule

// File: rtl/psum_gbf_reader.sv
// Reads a run of psum words from the global-buffer BRAM and streams each word
// out as OUT_BITWIDTH beats with valid/ready handshaking, one word in flight.
module psum_gbf_reader
  import psum_gbf_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int OUT_BITWIDTH      = 64,
  parameter int ADDR_BITWIDTH     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_BITWIDTH-1:0]     base_addr,
  input  logic [ADDR_BITWIDTH:0]       num_words,
  output logic                         psum_read_en,
  output logic [ADDR_BITWIDTH-1:0]     psum_BRAM_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0] psum_BRAM_data,
  output logic [OUT_BITWIDTH-1:0]      out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         rd_finish
);

  localparam int BEATS = beats_per_word(GBF_DATA_BITWIDTH, OUT_BITWIDTH);
  localparam int BCW   = beat_cnt_bits(BEATS);
  localparam int CNT_W = ADDR_BITWIDTH + 1;
  localparam logic [BCW-1:0] PEN_BEAT = BCW'(BEATS - 2);

  if ((GBF_DATA_BITWIDTH % OUT_BITWIDTH) != 0 || (OUT_BITWIDTH % DATA_BITWIDTH) != 0) begin : g_param_check
    $error("psum_gbf_reader: word width must be a multiple of beat width, beat of element");
  end

  state_t                 state;
  logic [ADDR_BITWIDTH-1:0] base_q;
  logic [CNT_W-1:0]       num_q;
  logic [CNT_W-1:0]       word_cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic                   last_word;
  logic [BCW-1:0]         beat_cnt;
  logic                   final_beat;

  assign next_cnt  = word_cnt + CNT_W'(1);
  assign last_word = (next_cnt == num_q);

  psum_word_serializer #(
    .GBF_DATA_BITWIDTH (GBF_DATA_BITWIDTH),
    .OUT_BITWIDTH      (OUT_BITWIDTH)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .capture    (state == WAIT),
    .advance    (out_valid && out_ready),
    .word_in    (psum_BRAM_data),
    .out_data   (out_data),
    .beat_cnt   (beat_cnt),
    .final_beat (final_beat)
  );

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      base_q         <= '0;
      num_q          <= '0;
      word_cnt       <= '0;
      psum_read_en   <= 1'b0;
      psum_BRAM_addr <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      rd_finish      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words != '0) begin
              base_q         <= base_addr;
              num_q          <= num_words;
              word_cnt       <= '0;
              psum_read_en   <= 1'b1;
              psum_BRAM_addr <= base_addr;
              state          <= REQ;
            end else begin
              rd_finish <= 1'b1;
              state     <= DONE;
            end
          end
        end
        REQ: begin
          psum_read_en <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          out_valid <= 1'b1;
          out_last  <= last_word && (BEATS == 1);
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (final_beat) begin
              word_cnt  <= next_cnt;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (last_word) begin
                rd_finish <= 1'b1;
                state     <= DONE;
              end else begin
                psum_read_en   <= 1'b1;
                psum_BRAM_addr <= base_q + next_cnt[ADDR_BITWIDTH-1:0];
                state          <= REQ;
              end
            end else begin
              // Flag the upcoming beat when it is the last one of the job.
              out_last <= last_word && (beat_cnt == PEN_BEAT);
            end
          end
        end
        DONE: begin
          rd_finish <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_gbf_reader.sv
// Directed self-checking bench for psum_gbf_reader with a one-cycle-latency BRAM model.
module tb_psum_gbf_reader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [10:0]  num_words = '0;
  logic         psum_read_en;
  logic [9:0]   psum_BRAM_addr;
  logic [511:0] psum_BRAM_data = '0;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;
  logic         rd_finish;

  int tests_run = 0;
  int tests_failed = 0;

  psum_gbf_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .psum_read_en   (psum_read_en),
    .psum_BRAM_addr (psum_BRAM_addr),
    .psum_BRAM_data (psum_BRAM_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .rd_finish      (rd_finish)
  );

  always #5 clk = ~clk;

  // Element k of the word at address a is ((a-5) mod 1024)*32 + k, so address 5 holds k at element k.
  function automatic logic [511:0] mem_word(input logic [9:0] a);
    logic [511:0] w;
    logic [9:0]   off;
    off = a - 10'd5;
    for (int k = 0; k < 32; k++) w[16*k +: 16] = {1'b0, off, 5'(k)};
    return w;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [9:0] a, input int j);
    logic [511:0] w;
    w = mem_word(a);
    return w[64*j +: 64];
  endfunction

  // BRAM model: data for a read appears only during the cycle after the strobe.
  initial begin
    logic       pend;
    logic [9:0] pend_addr;
    forever begin
      @(negedge clk);
      pend      = psum_read_en;
      pend_addr = psum_BRAM_addr;
      @(posedge clk);
      #1;
      psum_BRAM_data = pend ? mem_word(pend_addr) : {16{32'hDEADBEEF}};
    end
  end

  int ready_mode = 0;
  initial begin
    int ptn = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((ptn % 3) == 0);
      ptn++;
    end
  end

  logic [9:0]  rd_addr_q [$];
  int          rd_cyc_q [$];
  logic [63:0] beat_q [$];
  logic        beat_last_q [$];
  int          beat_cyc_q [$];
  int          fin_cyc_q [$];
  int          start_cyc, valid_cnt, hold_viol, cyc;
  logic        prev_valid, prev_ready, prev_last;
  logic [63:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (psum_read_en) begin rd_addr_q.push_back(psum_BRAM_addr); rd_cyc_q.push_back(cyc); end
    if (out_valid && out_ready) begin
      beat_q.push_back(out_data); beat_last_q.push_back(out_last); beat_cyc_q.push_back(cyc);
    end
    if (out_valid) valid_cnt++;
    if (rd_finish) fin_cyc_q.push_back(cyc);
    if (start && !busy && reset) start_cyc = cyc;
    if (reset && prev_valid && !prev_ready &&
        (!out_valid || out_data !== prev_data || out_last !== prev_last)) hold_viol++;
    prev_valid = out_valid && reset;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_addr_q.delete(); rd_cyc_q.delete(); beat_q.delete(); beat_last_q.delete();
    beat_cyc_q.delete(); fin_cyc_q.delete();
    start_cyc = -1; valid_cnt = 0; hold_viol = 0;
  endtask

  task automatic start_job(input logic [9:0] b, input logic [10:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL %s timeout: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  // Compares the streamed beats against the words at the listed addresses.
  task automatic check_stream(input string name, input logic [9:0] addrs [$]);
    int bad_data = 0, bad_last = 0, n;
    n = addrs.size() * 8;
    tests_run++;
    if (beat_q.size() !== n) begin
      tests_failed++;
      $display("[TB] FAIL %s beat count: got %0d, required %0d", name, beat_q.size(), n);
    end
    tests_run++;
    if (rd_addr_q.size() !== addrs.size()) begin
      tests_failed++;
      $display("[TB] FAIL %s read count: got %0d, required %0d", name, rd_addr_q.size(), addrs.size());
    end
    for (int i = 0; i < addrs.size() && i < rd_addr_q.size(); i++) begin
      tests_run++;
      if (rd_addr_q[i] !== addrs[i]) begin
        tests_failed++;
        $display("[TB] FAIL %s read %0d addr: got %0d, required %0d", name, i, rd_addr_q[i], addrs[i]);
      end
    end
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      if (beat_q[i] !== exp_beat(addrs[i/8], i % 8)) bad_data++;
      if (beat_last_q[i] !== (i == n - 1)) bad_last++;
    end
    tests_run++;
    if (bad_data !== 0) begin
      tests_failed++;
      $display("[TB] FAIL %s beat data: %0d wrong beats, required 0", name, bad_data);
    end
    tests_run++;
    if (bad_last !== 0) begin
      tests_failed++;
      $display("[TB] FAIL %s out_last: %0d wrong flags, required 0", name, bad_last);
    end
    tests_run++;
    if (fin_cyc_q.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL %s rd_finish pulses: got %0d, required 1", name, fin_cyc_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [84:0] all_out;
    all_out = {psum_read_en, psum_BRAM_addr, out_data, out_valid, out_last, busy, rd_finish};
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s outputs: rd_en=%b addr=%0d data=%h valid=%b last=%b busy=%b fin=%b, required all 0",
               name, psum_read_en, psum_BRAM_addr, out_data, out_valid, out_last, busy, rd_finish);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_single_word();
    logic [9:0] a [$] = '{10'd5};
    clear_mon(); ready_mode = 0;
    start_job(10'd5, 11'd1);
    wait_idle(60, "single");
    check_stream("single", a);
    tests_run++;
    if (beat_q.size() < 1 || beat_q[0] !== 64'h0003_0002_0001_0000) begin
      tests_failed++;
      $display("[TB] FAIL single beat0: got %h, required 0003000200010000", beat_q.size() ? beat_q[0] : 64'hx);
    end
    tests_run++;
    if (beat_cyc_q.size() != 8 || fin_cyc_q.size() != 1 || fin_cyc_q[0] !== beat_cyc_q[7] + 1) begin
      tests_failed++;
      $display("[TB] FAIL single finish timing: got cycle %0d, required last beat cycle + 1",
               fin_cyc_q.size() ? fin_cyc_q[0] : -1);
    end
    tests_run++;
    if (rd_cyc_q.size() != 1 || beat_cyc_q.size() < 1 || beat_cyc_q[0] !== rd_cyc_q[0] + 2) begin
      tests_failed++;
      $display("[TB] FAIL single first beat latency: got %0d, required 2",
               (beat_cyc_q.size() && rd_cyc_q.size()) ? beat_cyc_q[0] - rd_cyc_q[0] : -1);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] a [$] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    clear_mon(); ready_mode = 0;
    start_job(10'd1022, 11'd4);
    wait_idle(100, "wrap");
    check_stream("wrap", a);
    for (int i = 1; i < 4 && i < rd_cyc_q.size(); i++) begin
      tests_run++;
      if (rd_cyc_q[i] - rd_cyc_q[i-1] !== 10) begin
        tests_failed++;
        $display("[TB] FAIL wrap word spacing %0d: got %0d cycles, required 10", i, rd_cyc_q[i] - rd_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] a [$] = '{10'd300, 10'd301, 10'd302};
    clear_mon(); ready_mode = 1;
    start_job(10'd300, 11'd3);
    wait_idle(300, "backpressure");
    ready_mode = 0;
    check_stream("backpressure", a);
    tests_run++;
    if (hold_viol !== 0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure hold: %0d unstable stall cycles, required 0", hold_viol);
    end
    tests_run++;
    if (valid_cnt <= 24) begin
      tests_failed++;
      $display("[TB] FAIL backpressure stalls: got %0d valid cycles, required more than 24", valid_cnt);
    end
  endtask

  task automatic test_zero_length();
    clear_mon(); ready_mode = 0;
    start_job(10'd9, 11'd0);
    wait_idle(20, "zero");
    tick();
    tests_run++;
    if (rd_addr_q.size() !== 0 || valid_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL zero activity: got %0d reads %0d valid cycles, required 0 and 0", rd_addr_q.size(), valid_cnt);
    end
    tests_run++;
    if (fin_cyc_q.size() !== 1 || fin_cyc_q[0] !== start_cyc + 1) begin
      tests_failed++;
      $display("[TB] FAIL zero finish: got %0d pulses at cycle %0d, required 1 at %0d",
               fin_cyc_q.size(), fin_cyc_q.size() ? fin_cyc_q[0] : -1, start_cyc + 1);
    end
  endtask

  task automatic test_reset_mid_job();
    logic [9:0] a [$] = '{10'd600, 10'd601};
    int n = 0, reads_before;
    clear_mon(); ready_mode = 0;
    start_job(10'd400, 11'd3);
    while (beat_q.size() < 10 && n < 100) begin tick(); n++; end
    reset = 1'b0;
    tick();
    check_outputs_zero("mid_job_reset");
    reads_before = rd_addr_q.size();
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (reads_before !== 2 || rd_addr_q.size() !== 2 || fin_cyc_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort: got %0d/%0d reads %0d finishes, required 2/2 and 0",
               reads_before, rd_addr_q.size(), fin_cyc_q.size());
    end
    clear_mon();
    start_job(10'd600, 11'd2);
    wait_idle(60, "after_reset");
    check_stream("after_reset", a);
  endtask

  task automatic test_busy_start();
    logic [9:0] a [$] = '{10'd200, 10'd201};
    clear_mon(); ready_mode = 0;
    start_job(10'd200, 11'd2);
    repeat (3) tick();
    start = 1'b1; base_addr = 10'd7; num_words = 11'd3;
    tick();
    start = 1'b0;
    wait_idle(60, "busy_start");
    check_stream("busy_start", a);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_mon(); ready_mode = 0;
    start_job(10'd700, 11'd1);
    while (!rd_finish && n < 50) begin tick(); n++; end
    start = 1'b1; base_addr = 10'd50; num_words = 11'd1;
    repeat (2) tick();
    start = 1'b0;
    wait_idle(60, "back_to_back");
    tests_run++;
    if (rd_addr_q.size() !== 2 || fin_cyc_q.size() !== 2) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back counts: got %0d reads %0d finishes, required 2 and 2",
               rd_addr_q.size(), fin_cyc_q.size());
    end else begin
      tests_run++;
      if (rd_addr_q[0] !== 10'd700 || rd_addr_q[1] !== 10'd50) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back addrs: got %0d,%0d, required 700,50", rd_addr_q[0], rd_addr_q[1]);
      end
      tests_run++;
      if (rd_cyc_q[1] !== fin_cyc_q[0] + 2) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back restart: got %0d cycles after finish, required 2", rd_cyc_q[1] - fin_cyc_q[0]);
      end
    end
  endtask

  initial begin
    clear_mon();
    cyc = 0;
    test_reset();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_reset_mid_job();
    test_busy_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
